// File: rtl/eye_mon_pkg.sv
// Shared types and constants for the eye opening monitor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package eye_mon_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } eye_state_t;

    // Sentinels that any realistic receiver voltage beats on the first compare
    localparam real EYE_MON_POS_INF = 1.0e30;
    localparam real EYE_MON_NEG_INF = -1.0e30;

    // Width that holds 0..window without wrapping
    function automatic int eye_cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/eye_opening_monitor_if.sv
// Sample-in / opening-out bundle of the eye opening monitor.
// Latency: none (wiring only).
// Backpressure: none; samples are accepted every cycle, results are pulsed.
// Optional statistics signals are present when EYE_MON_STATS_EN is defined.
interface eye_opening_monitor_if
`ifdef EYE_MON_STATS_EN
    #(parameter int WINDOW = 256)
`endif
    ();

    logic enable;
    real  sample;
    logic sample_valid;
    logic data_bit;
    real  opening;
    logic opening_ready;
    logic degenerate;

`ifdef EYE_MON_STATS_EN
    localparam int CNT_W = $clog2(WINDOW + 1);
    real              min_one_out;
    real              max_zero_out;
    logic [CNT_W-1:0] cnt_one_out;
    logic [CNT_W-1:0] cnt_zero_out;

    modport master (
        output enable, sample, sample_valid, data_bit,
        input  opening, opening_ready, degenerate,
        input  min_one_out, max_zero_out, cnt_one_out, cnt_zero_out
    );

    modport slave (
        input  enable, sample, sample_valid, data_bit,
        output opening, opening_ready, degenerate,
        output min_one_out, max_zero_out, cnt_one_out, cnt_zero_out
    );
`else
    modport master (
        output enable, sample, sample_valid, data_bit,
        input  opening, opening_ready, degenerate
    );

    modport slave (
        input  enable, sample, sample_valid, data_bit,
        output opening, opening_ready, degenerate
    );
`endif

endinterface

// File: rtl/eye_class_tracker.sv
// Running extreme (min or max) and sample count for one training-bit class.
// Latency: value/count reflect an update on the following cycle.
// Backpressure: none; clear has priority over update.
module eye_class_tracker
    import eye_mon_pkg::*;
#(
    parameter bit MODE_MIN = 1'b1,
    parameter int CNT_W    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             update,
    input  real              sample,
    output real              value,
    output logic [CNT_W-1:0] count
);

    localparam real INIT_VAL = MODE_MIN ? EYE_MON_POS_INF : EYE_MON_NEG_INF;

    real              r_value;
    logic [CNT_W-1:0] r_count;
    logic             w_better;

    // Strict compare so a sample equal to the current extreme leaves it alone
    always_comb begin
        w_better = MODE_MIN ? (sample < r_value) : (sample > r_value);
    end

    // Extreme and count registers, restarted on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= INIT_VAL;
            r_count <= '0;
        end else if (clear) begin
            r_value <= INIT_VAL;
            r_count <= '0;
        end else if (update) begin
            if (w_better) begin
                r_value <= sample;
            end
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign value = r_value;
    assign count = r_count;

endmodule

// File: rtl/eye_opening_monitor.sv
// Vertical eye opening = min(bit-1 samples) - max(bit-0 samples) per WINDOW valid samples.
// Latency: opening/opening_ready register on the edge after the one accepting the last sample.
// Backpressure: none; samples during settle, gaps or enable=0 are simply ignored.
// Build option EYE_MON_STATS_EN adds per-window min/max/count outputs.
module eye_opening_monitor
    import eye_mon_pkg::*;
#(
    parameter int WINDOW        = 256,
    parameter int SETTLE_CYCLES = 32,
    parameter int MIN_PER_CLASS = 8
) (
    input  logic                  clock_with_shift,
    input  logic                  reset_n,
    eye_opening_monitor_if.slave  mon
);

    localparam int CNT_W = eye_cnt_width(WINDOW);
    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    eye_state_t       r_state;
    eye_state_t       w_state_nxt;
    logic [SET_W-1:0] r_settle_cnt;
    logic [SET_W-1:0] w_settle_nxt;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] w_win_nxt;
    logic             w_clear;
    logic             w_upd_one;
    logic             w_upd_zero;
    logic             w_report;
    logic             w_enough;

    real              w_min_one;
    real              w_max_zero;
    logic [CNT_W-1:0] w_cnt_one;
    logic [CNT_W-1:0] w_cnt_zero;

    real              r_opening;
    logic             r_ready;
    logic             r_degenerate;

    // Bit-1 class keeps the lowest sample, bit-0 class keeps the highest
    eye_class_tracker #(.MODE_MIN(1'b1), .CNT_W(CNT_W)) u_trk_one (
        .clk    (clock_with_shift),
        .rst_n  (reset_n),
        .clear  (w_clear),
        .update (w_upd_one),
        .sample (mon.sample),
        .value  (w_min_one),
        .count  (w_cnt_one)
    );

    eye_class_tracker #(.MODE_MIN(1'b0), .CNT_W(CNT_W)) u_trk_zero (
        .clk    (clock_with_shift),
        .rst_n  (reset_n),
        .clear  (w_clear),
        .update (w_upd_zero),
        .sample (mon.sample),
        .value  (w_max_zero),
        .count  (w_cnt_zero)
    );

    // State, settle counter and window counter registers
    always_ff @(posedge clock_with_shift or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= SETTLE;
            r_settle_cnt <= '0;
            r_win_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_win_cnt    <= w_win_nxt;
        end
    end

    // Next state and tracker controls; enable low overrides every state
    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        w_win_nxt    = r_win_cnt;
        w_clear      = 1'b0;
        w_upd_one    = 1'b0;
        w_upd_zero   = 1'b0;
        w_report     = 1'b0;
        if (!mon.enable) begin
            w_state_nxt  = SETTLE;
            w_settle_nxt = '0;
            w_win_nxt    = '0;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                SETTLE: begin
                    if (r_settle_cnt == SET_W'(SETTLE_CYCLES)) begin
                        w_state_nxt = ACCUM;
                        w_win_nxt   = '0;
                        w_clear     = 1'b1;
                    end else begin
                        w_settle_nxt = r_settle_cnt + SET_W'(1);
                    end
                end
                ACCUM: begin
                    if (mon.sample_valid) begin
                        w_upd_one  = mon.data_bit;
                        w_upd_zero = !mon.data_bit;
                        w_win_nxt  = r_win_cnt + CNT_W'(1);
                        if (r_win_cnt == CNT_W'(WINDOW - 1)) begin
                            w_state_nxt = REPORT;
                        end
                    end
                end
                REPORT: begin
                    w_report     = 1'b1;
                    w_state_nxt  = SETTLE;
                    w_settle_nxt = '0;
                end
                default: begin
                    w_state_nxt  = SETTLE;
                    w_settle_nxt = '0;
                end
            endcase
        end
    end

    // A window is trustworthy only with enough samples of both classes
    always_comb begin
        w_enough = (32'(w_cnt_one) >= 32'(MIN_PER_CLASS)) &&
                   (32'(w_cnt_zero) >= 32'(MIN_PER_CLASS));
    end

    // Result registers: one-cycle ready pulse, opening/degenerate held between reports
    always_ff @(posedge clock_with_shift or negedge reset_n) begin
        if (!reset_n) begin
            r_opening    <= 0.0;
            r_ready      <= 1'b0;
            r_degenerate <= 1'b0;
        end else begin
            r_ready <= w_report;
            if (w_report) begin
                if (w_enough) begin
                    r_opening    <= w_min_one - w_max_zero;
                    r_degenerate <= 1'b0;
                end else begin
                    r_opening    <= 0.0;
                    r_degenerate <= 1'b1;
                end
            end
        end
    end

    assign mon.opening       = r_opening;
    assign mon.opening_ready = r_ready;
    assign mon.degenerate    = r_degenerate;

`ifdef EYE_MON_STATS_EN
    real              r_min_one_out;
    real              r_max_zero_out;
    logic [CNT_W-1:0] r_cnt_one_out;
    logic [CNT_W-1:0] r_cnt_zero_out;

    // Raw per-window tracker snapshot, captured with every report
    always_ff @(posedge clock_with_shift or negedge reset_n) begin
        if (!reset_n) begin
            r_min_one_out  <= 0.0;
            r_max_zero_out <= 0.0;
            r_cnt_one_out  <= '0;
            r_cnt_zero_out <= '0;
        end else if (w_report) begin
            r_min_one_out  <= w_min_one;
            r_max_zero_out <= w_max_zero;
            r_cnt_one_out  <= w_cnt_one;
            r_cnt_zero_out <= w_cnt_zero;
        end
    end

    assign mon.min_one_out  = r_min_one_out;
    assign mon.max_zero_out = r_max_zero_out;
    assign mon.cnt_one_out  = r_cnt_one_out;
    assign mon.cnt_zero_out = r_cnt_zero_out;
`endif

endmodule
